// File: rtl/matriz_scan_ctrl.sv
// Row-scan timing and image sequencer for the 7x5 LED matrix.
// Blanks between rows and swaps images only on frame boundaries, so the display never tears.
module matriz_scan_ctrl #(
  parameter int ROW_CYC      = 1000,
  parameter int GUARD_CYC    = 2,
  parameter int DWELL_FRAMES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] nivel,
  input  logic       rega_ativa,
  input  logic       rega_tipo,
  output logic [2:0] sel,
  output logic [2:0] img_sel,
  output logic       blank,
  output logic       fase,
  output logic       frame_tick
);

  localparam int CYC_MAX = (ROW_CYC > GUARD_CYC) ? ROW_CYC : GUARD_CYC;
  localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int FW      = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [FW-1:0] DWELL_LAST = FW'(DWELL_FRAMES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  // Without blanking, a row hands over straight to the next row.
  localparam logic [1:0] ST_PRE_ROW = (GUARD_CYC == 0) ? ST_SCAN : ST_GUARD;

  localparam logic [2:0] SEL_OFF  = 3'd7;
  localparam logic [2:0] ROW_LAST_IDX = 3'd6;

  logic [1:0]    state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          fase_q, fase_d;
  logic [1:0]    nivel_q, nivel_d;
  logic          ativa_q, ativa_d;
  logic          tipo_q, tipo_d;
  logic          tick_d;
  logic [2:0]    sel_d;
  logic [2:0]    img_d;
  logic          blank_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cyc_d   = cyc_q;
    frame_d = frame_q;
    fase_d  = fase_q;
    nivel_d = nivel_q;
    ativa_d = ativa_q;
    tipo_d  = tipo_q;
    tick_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          nivel_d = nivel;
          ativa_d = rega_ativa;
          tipo_d  = rega_tipo;
          row_d   = 3'd0;
          cyc_d   = '0;
          fase_d  = 1'b0;
          frame_d = '0;
          state_d = ST_PRE_ROW;
        end
      end

      ST_GUARD: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
        end else if (cyc_q == GUARD_LAST) begin
          cyc_d   = '0;
          state_d = ST_SCAN;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_SCAN: begin
        if (!enable) begin
          // Abort wins over a coinciding frame boundary: no tick, image held.
          state_d = ST_IDLE;
          cyc_d   = '0;
        end else if (cyc_q == ROW_LAST) begin
          cyc_d   = '0;
          state_d = ST_PRE_ROW;
          if (row_q == ROW_LAST_IDX) begin
            row_d   = 3'd0;
            tick_d  = 1'b1;
            nivel_d = nivel;
            ativa_d = rega_ativa;
            tipo_d  = rega_tipo;
            if (!rega_ativa) begin
              fase_d  = 1'b0;
              frame_d = '0;
            end else if (frame_q == DWELL_LAST) begin
              frame_d = '0;
              fase_d  = ~fase_q;
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        row_d   = 3'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    sel_d   = (state_d == ST_SCAN) ? row_d : SEL_OFF;
    blank_d = (state_d != ST_SCAN);
    img_d   = fase_d ? {2'b10, tipo_d} : {1'b0, nivel_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= 3'd0;
      cyc_q      <= '0;
      frame_q    <= '0;
      fase_q     <= 1'b0;
      nivel_q    <= 2'd0;
      ativa_q    <= 1'b0;
      tipo_q     <= 1'b0;
      sel        <= SEL_OFF;
      img_sel    <= 3'd0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cyc_q      <= cyc_d;
      frame_q    <= frame_d;
      fase_q     <= fase_d;
      nivel_q    <= nivel_d;
      ativa_q    <= ativa_d;
      tipo_q     <= tipo_d;
      sel        <= sel_d;
      img_sel    <= img_d;
      blank      <= blank_d;
      frame_tick <= tick_d;
    end
  end

  assign fase = fase_q;

endmodule

// File: doc/matriz_scan_ctrl.md
Name: matriz_scan_ctrl

Overview:
Timing generator and image sequencer that drives the 7x5 LED matrix display block. It produces the fast row-scan select and the slow image select that the matrix consumes. The image select alternates between the soil-moisture level image and the irrigation-type image. It sits between the irrigation control logic (level and rega status) and the matrix driver, and guarantees tear-free, ghost-free scanning.

Parameters:
ROW_CYC, 1000, clock cycles each row is lit (>=1)
GUARD_CYC, 2, blanking cycles between consecutive rows (0 = no blanking)
DWELL_FRAMES, 500, full 7-row frames shown per image before alternating (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan display; 0 = display dark
nivel  in  2  level image index: 0 Crit, 1 Baix, 2 Medi, 3 Alto
rega_ativa  in  1  1 = irrigation active, so the type image joins the alternation
rega_tipo  in  1  0 = Aspe (aspersao), 1 = Gote (gotejamento)
sel  out  3  row select to the matrix: 0..6 = lit row, 7 = no row lit
img_sel  out  3  image select to the matrix: 0..3 = level image, 4..5 = rega image
blank  out  1  1 when no row is lit (sel==7)
fase  out  1  0 = level image shown, 1 = rega image shown
frame_tick  out  1  one-cycle pulse at the end of each complete frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: state IDLE, sel=7, img_sel=0, blank=1, fase=0, frame_tick=0. Row, cycle and frame counters are 0. The latched copies of nivel, rega_ativa and rega_tipo are 0.
- The FSM has three states: IDLE, GUARD and SCAN.
- IDLE:
  - Outputs: sel=7, blank=1.
  - When enable=1 is seen on a clock edge: latch nivel, rega_ativa and rega_tipo; set row=0, fase=0, frame count=0.
  - Next state is GUARD, or SCAN directly if GUARD_CYC=0.
- GUARD:
  - Outputs: sel=7, blank=1.
  - Stays exactly GUARD_CYC cycles, then goes to SCAN.
- SCAN:
  - Outputs: sel=row, blank=0.
  - Stays exactly ROW_CYC cycles.
  - On the last cycle, if row<6: row increments, and the next state is GUARD (or SCAN if GUARD_CYC=0).
  - On the last cycle, if row==6, a frame boundary occurs (see next item).
- Frame boundary (last SCAN cycle of row 6):
  - row wraps to 0.
  - frame_tick=1 for the following single cycle.
  - Inputs are re-latched, so the image never changes mid-frame.
  - Frame count increments. When it reaches DWELL_FRAMES it clears to 0 and fase toggles, provided the latched rega_ativa is 1.
  - If the newly latched rega_ativa=0: fase is forced to 0 and the frame count is cleared.
- img_sel:
  - fase=0: {1'b0, nivel_latched}.
  - fase=1: {2'b10, rega_tipo_latched}.
  - img_sel changes only at a frame boundary or on entry from IDLE.
- Row period: ROW_CYC+GUARD_CYC cycles. Frame period: 7×(ROW_CYC+GUARD_CYC).
- Immediate stop: enable=0 on any edge in GUARD or SCAN forces IDLE on that edge. sel=7 and blank=1 appear on the next output. fase and img_sel hold their values. No frame_tick is issued.
- Reset mid-operation: outputs return to reset values immediately and asynchronously.
- Counter widths: each is $clog2 of its maximum, with a minimum of 1 bit. No arithmetic overflow is permitted.
- sel never takes a value other than 0..6 or 7. blank==(sel==7) holds at all times.

Test Plan:
Use ROW_CYC=4, GUARD_CYC=1, DWELL_FRAMES=2 unless stated otherwise.
1. Reset with rst_n=0 held mid-scan, asynchronously -> sel=7, blank=1, img_sel=0, fase=0, frame_tick=0 without a clock edge.
2. enable=1, nivel=2, rega_ativa=0 -> pattern of 1 cycle sel=7 then 4 cycles sel=k, for k=0..6. frame_tick pulses every 35 cycles. img_sel stays 2 and fase stays 0 indefinitely.
3. nivel=1, rega_ativa=1, rega_tipo=1 -> img_sel=1 for frames 0–1, then 5 for frames 2–3, then 1 again. Switches occur only in the cycle after frame_tick.
4. Change nivel 0→3 during row 3 -> img_sel stays 0 until the frame boundary, then becomes 3 (when fase=0). No mid-frame change.
5. enable dropped during SCAN row 4 -> sel=7 on the next cycle, and no frame_tick. Re-enable -> GUARD first, then scanning restarts at row 0 with fase=0.
6. GUARD_CYC=0, ROW_CYC=1 -> sel steps 0,1,...,6,0 every cycle. blank is never 1 after start. frame_tick pulses every 7 cycles.
